// File: rtl/run_sequencer.sv
// Run sequencer: holds a core in reset, releases it at a selected program's start PC,
// then tracks completion or timeout and holds the result until the request drops.
module run_sequencer #(
    parameter int unsigned INIT_CYCLES    = 2,
    parameter int unsigned DRAIN_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [11:0] PROG0_ADDR     = 12'h000,
    parameter logic [11:0] PROG1_ADDR     = 12'h100,
    parameter logic [11:0] PROG2_ADDR     = 12'h200,
    parameter logic [11:0] PROG3_ADDR     = 12'h300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  prog_id,
    input  logic        core_done,
    output logic        core_reset,
    output logic        core_en,
    output logic [11:0] start_addr,
    output logic        done,
    output logic        err,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

    state_t      state, next_state;
    logic        req_q;
    logic        armed;
    logic [31:0] phase_cnt, phase_next;
    logic [15:0] count_next, count_inc;
    logic        err_next;
    logic [11:0] addr_next, prog_addr;
    logic        done_seen;

    always_comb begin
        next_state = state;
        phase_next = phase_cnt;
        count_next = cycle_count;
        err_next   = err;
        addr_next  = start_addr;
        count_inc  = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        // X/Z on core_done falls to the else branch, so only a clean 1 counts
        done_seen  = 1'b0;
        if (core_done == 1'b1) done_seen = 1'b1;

        case (prog_id)
            2'd0:    prog_addr = PROG0_ADDR;
            2'd1:    prog_addr = PROG1_ADDR;
            2'd2:    prog_addr = PROG2_ADDR;
            default: prog_addr = PROG3_ADDR;
        endcase

        case (state)
            IDLE: begin
                if (req && !req_q && armed) begin
                    addr_next  = prog_addr;
                    count_next = '0;
                    err_next   = 1'b0;
                    phase_next = '0;
                    next_state = INIT;
                end
            end
            INIT: begin
                if (phase_cnt + 32'd1 >= INIT_CYCLES) begin
                    phase_next = '0;
                    next_state = RUN;
                end else begin
                    phase_next = phase_cnt + 32'd1;
                end
            end
            RUN: begin
                count_next = count_inc;
                if (done_seen) begin
                    phase_next = '0;
                    next_state = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end else if ({16'd0, count_inc} == TIMEOUT_CYCLES) begin
                    err_next   = 1'b1;
                    next_state = DONE;
                end
            end
            DRAIN: begin
                if (phase_cnt + 32'd1 >= DRAIN_CYCLES) begin
                    phase_next = '0;
                    next_state = DONE;
                end else begin
                    phase_next = phase_cnt + 32'd1;
                end
            end
            DONE: begin
                if (!req) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // armed blocks a req level held high through reset from looking like a rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            armed       <= 1'b0;
            phase_cnt   <= '0;
            cycle_count <= '0;
            err         <= 1'b0;
            start_addr  <= PROG0_ADDR;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            req_q       <= req;
            armed       <= armed | ~req;
            phase_cnt   <= phase_next;
            cycle_count <= count_next;
            err         <= err_next;
            start_addr  <= addr_next;
            core_reset  <= (next_state == IDLE) || (next_state == INIT);
            core_en     <= (next_state == RUN) || (next_state == DRAIN);
            done        <= (next_state == DONE);
        end
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2: cycles core_reset is held after a start.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 1: cycles core_en stays high after core_done.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: RUN cycles before the run is aborted.
REQ-004 SHALL have parameters PROG0_ADDR..PROG3_ADDR, defaults 12'h000, 12'h100, 12'h200, 12'h300: start PC per program.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port req, input, 1: start request, level from testbench.
REQ-008 SHALL have port prog_id, input, 2: program select, captured on start.
REQ-009 SHALL have port core_done, input, 1: program_done from the core.
REQ-010 SHALL have port core_reset, output, 1: reset driven to the core's PC.
REQ-011 SHALL have port core_en, output, 1: core run enable.
REQ-012 SHALL have port start_addr, output, 12: start PC of the selected program.
REQ-013 SHALL have port done, output, 1: run complete.
REQ-014 SHALL have port err, output, 1: run ended by timeout.
REQ-015 SHALL have port cycle_count, output, 16: RUN cycles in the current or last run.

Function
REQ-016 SHALL register all outputs; no combinational input-to-output path.
REQ-017 SHALL implement the states IDLE, INIT, RUN, DRAIN and DONE.
REQ-018 SHALL detect a start only in IDLE, as req==1 with req sampled 0 on the previous edge (rising edge).
- A level held high from reset is not a start.
REQ-019 On a start, SHALL on the same edge:
- load start_addr from PROGn_ADDR indexed by prog_id;
- clear cycle_count and err;
- enter INIT.
REQ-020 In IDLE and INIT, SHALL drive core_reset=1 and core_en=0.
REQ-021 SHALL remain in INIT for exactly INIT_CYCLES edges, then enter RUN.
- INIT_CYCLES=0 goes directly to RUN on the next edge.
REQ-022 In RUN and DRAIN, SHALL drive core_reset=0 and core_en=1.
REQ-023 SHALL increment cycle_count on every edge at which state is RUN, including the edge that samples core_done.
- cycle_count saturates at 16'hFFFF.
REQ-024 SHALL treat core_done as asserted only when it is exactly 1; X or Z SHALL be treated as 0.
REQ-025 In RUN, core_done sampled 1 SHALL cause:
- transition to DRAIN, or to DONE if DRAIN_CYCLES=0;
- err remains 0.
REQ-026 In RUN, when the increment makes cycle_count equal TIMEOUT_CYCLES and core_done is 0, SHALL set err=1 and enter DONE.
REQ-027 core_done and timeout on the same edge: core_done SHALL win and err SHALL stay 0.
REQ-028 SHALL remain in DRAIN for exactly DRAIN_CYCLES edges, then enter DONE.
REQ-029 In DONE, SHALL drive done=1, core_en=0 and core_reset=0, so the core state is held for readback.
REQ-030 SHALL leave DONE on the first edge that samples req==0, entering IDLE with done=0.
REQ-031 SHALL hold cycle_count, err and start_addr stable from DONE until the next start.
REQ-032 SHALL ignore req and prog_id changes in INIT, RUN and DRAIN; there is no abort.
REQ-033 SHALL keep done=0 in every state except DONE.

Reset
REQ-034 While reset=1 at an edge, SHALL set:
- state=IDLE, core_reset=1, core_en=0;
- done=0, err=0, cycle_count=0;
- start_addr=PROG0_ADDR;
- internal req history=0.
REQ-035 Reset SHALL take priority over every other event, including mid-INIT, RUN, DRAIN or DONE.
REQ-036 After reset, SHALL require a new rising edge of req before starting.

Verification
REQ-037 Start with prog_id=2 and req 0->1 sampled at edge n SHALL produce:
- start_addr=12'h200 and core_reset=1 after edge n;
- core_en=1 and core_reset=0 after edge n+2.
REQ-038 core_done=1 sampled on the 10th RUN edge, defaults, SHALL produce:
- cycle_count=10;
- DRAIN for 1 edge, then done=1, err=0, core_en=0;
- done held until req=0 is sampled, then done=0.
REQ-039 TIMEOUT_CYCLES=8 with core_done held 0 SHALL produce err=1, done=1 and cycle_count=8 on the 8th RUN edge.
REQ-040 TIMEOUT_CYCLES=8 with core_done=1 on the 8th RUN edge SHALL produce err=0 and normal drain.
REQ-041 reset=1 asserted mid-RUN (cycle_count=5) SHALL produce:
- after the next edge: core_reset=1, core_en=0, cycle_count=0, start_addr=12'h000;
- no restart while req stays high.
REQ-042 core_done=X during RUN SHALL cause no transition; counting SHALL continue.
